adder_nb_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor, the successor to the fixed 4-bit ripple adder in the datapath library. Operands of WIDTH bits are latched on a start handshake and processed CHUNK bits per clock through a registered carry, with the carry registered between chunks. Adds subtract mode, carry/borrow-in, signed overflow and a done pulse. Area-constrained arithmetic users trade latency for a narrow carry chain.

---
 rtl/adder_nb_seq.sv | 148 ++++++++++++++
 tb/tb_adder_nb_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nb_seq.sv
// adder_nb_seq: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// Operands are latched on an accepted START. The carry is held in a register
// between chunks, so the combinational carry chain is only CHUNK bits long.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for START; READY high, S/CO/OVF hold the last result
// BUSY  | one chunk per clock, chunk index in cnt_q; READY low
// DONE  | single-cycle result strobe; READY high, START accepted here
module adder_nb_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             carry_top;
    logic             accept;

    // Select the operand chunk addressed by cnt_q and add it with the stored carry.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(c_q);
        // Carry into the top bit of the chunk, recovered from its sum bit.
        carry_top = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    // Next-state and datapath update; subtraction is A + ~B + ~borrow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        accept  = START & ready_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    a_d     = A;
                    b_d     = SUB ? ~B : B;
                    c_d     = SUB ? ~CI : CI;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                c_d = chunk_sum[CHUNK];
                if (cnt_q == CW'(N - 1)) begin
                    co_d    = chunk_sum[CHUNK];
                    ovf_d   = carry_top ^ chunk_sum[CHUNK];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_BUSY);
        done_d  = (state_d == ST_DONE);
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign READY = ready_q;
    assign DONE  = done_q;
    assign S     = s_q;
    assign CO    = co_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_adder_nb_seq.sv
// Bench for adder_nb_seq: three configurations (16/4, 16/16, 8/1) on a shared
// reset and operand bus, each with its own START.
module tb_adder_nb_seq;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        ci_in = 1'b0;
    logic        sub_in = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;

    logic        ready0, done0, co0, ovf0;
    logic [15:0] s0;
    logic        ready1, done1, co1, ovf1;
    logic [15:0] s1;
    logic        ready2, done2, co2, ovf2;
    logic [7:0]  s2;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    adder_nb_seq #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .CLK(clk), .RST(rst), .START(start0), .A(a_in), .B(b_in), .CI(ci_in), .SUB(sub_in),
        .READY(ready0), .DONE(done0), .S(s0), .CO(co0), .OVF(ovf0)
    );

    adder_nb_seq #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start1), .A(a_in), .B(b_in), .CI(ci_in), .SUB(sub_in),
        .READY(ready1), .DONE(done1), .S(s1), .CO(co1), .OVF(ovf1)
    );

    adder_nb_seq #(.WIDTH(8), .CHUNK(1)) u_dut2 (
        .CLK(clk), .RST(rst), .START(start2), .A(a_in[7:0]), .B(b_in[7:0]), .CI(ci_in), .SUB(sub_in),
        .READY(ready2), .DONE(done2), .S(s2), .CO(co2), .OVF(ovf2)
    );

    // Whole-word behavioural reference for a w-bit add/subtract.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sub);
        logic [16:0] mask, aa, bb, full;
        exp_t r;
        mask  = (17'd1 << w) - 17'd1;
        aa    = {1'b0, a} & mask;
        bb    = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full  = aa + bb + {16'd0, (sub ? ~ci : ci)};
        r.s   = full[15:0] & mask[15:0];
        r.co  = full[w];
        r.ovf = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (s0 !== 16'h0000) $display("FAIL reset_s: got %h want %h", s0, 16'h0000); else n_pass++;
        n_checks++; if (co0 !== 1'b0) $display("FAIL reset_co: got %b want 0", co0); else n_pass++;
        n_checks++; if (ovf0 !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf0); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else n_pass++;
        n_checks++; if (ready0 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready0); else n_pass++;
        n_checks++; if ({ready1, ready2} !== 2'b11) $display("FAIL reset_ready_cfg: got %b want 11", {ready1, ready2}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation on the 16/4 instance with timing, result and hold checks.
    task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sub,
                           input logic [15:0] es, input logic eco, input logic eovf);
        exp_t e, g;
        int   k, ready_low;
        bit   got;
        e.s = es; e.co = eco; e.ovf = eovf;
        sb_q.push_back(e);
        @(negedge clk);
        a_in = a; b_in = b; ci_in = ci; sub_in = sub; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom); ci_in = 1'($urandom); sub_in = 1'($urandom);
        k = 0; ready_low = 0; got = 1'b0;
        while (!got && k < 20) begin
            if (done0) got = 1'b1;
            else begin
                if (!ready0) ready_low++;
                @(negedge clk);
                k++;
            end
        end
        n_checks++; if (!got || k != 4) $display("FAIL %s_latency: got %0d cycles (done seen %0b) want 4", name, k, got); else n_pass++;
        n_checks++; if (ready_low != 4) $display("FAIL %s_ready_low: got %0d cycles want 4", name, ready_low); else n_pass++;
        if (got && sb_q.size() > 0) begin
            g = sb_q.pop_front();
            n_checks++; if (s0 !== g.s) $display("FAIL %s_s: got %h want %h", name, s0, g.s); else n_pass++;
            n_checks++; if (co0 !== g.co) $display("FAIL %s_co: got %b want %b", name, co0, g.co); else n_pass++;
            n_checks++; if (ovf0 !== g.ovf) $display("FAIL %s_ovf: got %b want %b", name, ovf0, g.ovf); else n_pass++;
            @(negedge clk);
            n_checks++; if (done0 !== 1'b0) $display("FAIL %s_done_width: got %b want 0", name, done0); else n_pass++;
            n_checks++; if (s0 !== g.s) $display("FAIL %s_s_hold: got %h want %h", name, s0, g.s); else n_pass++;
        end else begin
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        a_in = 16'h1111; b_in = 16'h2222; ci_in = 1'b0; sub_in = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        n_checks++; if (s0[3:0] !== 4'h3) $display("FAIL mid_partial_s: got %h want 3", s0[3:0]); else n_pass++;
        n_checks++; if (ready0 !== 1'b0) $display("FAIL mid_ready_busy: got %b want 0", ready0); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (s0 !== 16'h0000) $display("FAIL mid_rst_s: got %h want 0000", s0); else n_pass++;
        n_checks++; if (co0 !== 1'b0) $display("FAIL mid_rst_co: got %b want 0", co0); else n_pass++;
        n_checks++; if (ovf0 !== 1'b0) $display("FAIL mid_rst_ovf: got %b want 0", ovf0); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", done0); else n_pass++;
        n_checks++; if (ready0 !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", ready0); else n_pass++;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL mid_rst_no_done: got %b want 0", seen); else n_pass++;
        test_op("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        exp_t e, g;
        int   dones, k1, k2;
        e.s = 16'h2345; e.co = 1'b0; e.ovf = 1'b0;
        sb_q.push_back(e);
        dones = 0; k1 = -1; k2 = -1;
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h1111; ci_in = 1'b0; sub_in = 1'b0; start0 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done0) begin
                dones++;
                if (dones == 1) k1 = k;
                else if (dones == 2) k2 = k;
                if (sb_q.size() > 0) begin
                    g = sb_q.pop_front();
                    n_checks++; if (s0 !== g.s) $display("FAIL b2b_s%0d: got %h want %h", dones, s0, g.s); else n_pass++;
                    n_checks++; if ({co0, ovf0} !== {g.co, g.ovf}) $display("FAIL b2b_flags%0d: got %b want %b", dones, {co0, ovf0}, {g.co, g.ovf}); else n_pass++;
                end
            end
            if (k == 4) begin
                a_in = 16'h00FF; b_in = 16'h0001; ci_in = 1'b0; sub_in = 1'b0;
                e.s = 16'h0100; e.co = 1'b0; e.ovf = 1'b0;
                sb_q.push_back(e);
            end else begin
                a_in = 16'($urandom); b_in = 16'($urandom); ci_in = 1'($urandom); sub_in = 1'($urandom);
            end
            if (k >= 5 && k <= 8) start0 = 1'(k % 2);
            if (k == 9) start0 = 1'b0;
        end
        n_checks++; if (dones != 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else n_pass++;
        n_checks++; if (k1 != 4 || k2 != 9) $display("FAIL b2b_done_timing: got %0d,%0d want 4,9", k1, k2); else n_pass++;
        sb_q.delete();
    endtask

    // Random ops on the 16/16 (cfg 1) or 8/1 (cfg 2) instance, START held high.
    task automatic test_sweep(input int cfg);
        int          w, n, k;
        bit          got;
        exp_t        g;
        logic        d, co, ov;
        logic [15:0] so;
        w = (cfg == 1) ? 16 : 8;
        n = (cfg == 1) ? 1 : 8;
        sb_q.delete();
        @(negedge clk);
        a_in = 16'($urandom); b_in = 16'($urandom); ci_in = 1'($urandom); sub_in = 1'($urandom);
        sb_q.push_back(model(w, a_in, b_in, ci_in, sub_in));
        if (cfg == 1) start1 = 1'b1; else start2 = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            k = -1; got = 1'b0;
            d = 1'b0; so = '0; co = 1'b0; ov = 1'b0;
            while (!got && k < n + 5) begin
                @(negedge clk);
                k++;
                if (cfg == 1) begin d = done1; so = s1; co = co1; ov = ovf1; end
                else begin d = done2; so = {8'h00, s2}; co = co2; ov = ovf2; end
                if (d) got = 1'b1;
            end
            n_checks++; if (!got || k != n) $display("FAIL sweep%0d_latency op %0d: got %0d (done seen %0b) want %0d", cfg, op, k, got, n); else n_pass++;
            if (got && sb_q.size() > 0) begin
                g = sb_q.pop_front();
                n_checks++; if (so !== g.s) $display("FAIL sweep%0d_s op %0d: got %h want %h", cfg, op, so, g.s); else n_pass++;
                n_checks++; if (co !== g.co) $display("FAIL sweep%0d_co op %0d: got %b want %b", cfg, op, co, g.co); else n_pass++;
                n_checks++; if (ov !== g.ovf) $display("FAIL sweep%0d_ovf op %0d: got %b want %b", cfg, op, ov, g.ovf); else n_pass++;
            end else begin
                sb_q.delete();
            end
            if (op < 999) begin
                a_in = 16'($urandom); b_in = 16'($urandom); ci_in = 1'($urandom); sub_in = 1'($urandom);
                sb_q.push_back(model(w, a_in, b_in, ci_in, sub_in));
            end else begin
                start1 = 1'b0;
                start2 = 1'b0;
            end
        end
        repeat (n + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_op("sub",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_op("borrow_in", 16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        test_reset_mid();
        test_back_to_back();
        test_sweep(1);
        test_sweep(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
